// File: rtl/rgb_expand.sv
// Expands a 3-bit per-channel code stream back to full-width RGB pixels,
// repeating each code AVERAGE_OVER times behind a small input code FIFO.
module rgb_expand #(
   parameter int COLOUR_DEPTH = 8,
   parameter int AVERAGE_OVER = 3,
   parameter int FIFO_DEPTH   = 4,
   parameter int HIGH_LEVEL   = 2**COLOUR_DEPTH-1,
   parameter int LOW_LEVEL    = 0
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic [2:0]                compressed_in,
   input  logic                      last_in,
   input  logic                      valid_in,
   output logic                      ready_out,
   output logic [3*COLOUR_DEPTH-1:0] rgb_out,
   output logic                      last_out,
   output logic                      valid_out,
   input  logic                      ready_in,
   output logic [31:0]               pixel_count_out
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; a held valid keeps its payload stable until it is taken.

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REP_W = $clog2(AVERAGE_OVER) + 1;
   localparam int PIX_W = 3 * COLOUR_DEPTH;

   localparam logic [COLOUR_DEPTH-1:0] HI_C       = COLOUR_DEPTH'(HIGH_LEVEL);
   localparam logic [COLOUR_DEPTH-1:0] LO_C       = COLOUR_DEPTH'(LOW_LEVEL);
   localparam logic [REP_W-1:0]        REP_LAST_C = REP_W'(AVERAGE_OVER - 1);
   localparam logic [CNT_W-1:0]        DEPTH_C    = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic               code_last_q, code_last_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic [31:0]        pixel_count_q, pixel_count_d;
   logic               ready_q, ready_d;

   logic [3:0]         mem_q [FIFO_DEPTH];
   logic [3:0]         mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;

   logic               push;
   logic               pop;
   logic               load;
   logic               out_xfer;
   logic [3:0]         head;

   function automatic logic [PIX_W-1:0] expand(input logic [2:0] code);
      expand = {code[2] ? HI_C : LO_C,
                code[1] ? HI_C : LO_C,
                code[0] ? HI_C : LO_C};
   endfunction

   assign head     = mem_q[rd_ptr_q];
   assign push     = valid_in && ready_q;
   assign out_xfer = valid_q && ready_in;

   always_comb begin
      state_d     = state_q;
      rep_d       = rep_q;
      pix_d       = pix_q;
      code_last_d = code_last_q;
      valid_d     = valid_q;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            if (fifo_cnt_q != '0) begin
               load    = 1'b1;
               valid_d = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_xfer) begin
               if (rep_q != REP_LAST_C) begin
                  rep_d = rep_q + REP_W'(1);
               end else if (fifo_cnt_q != '0) begin
                  // Next code is loaded on the same edge so replicas run gap-free.
                  load = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         pix_d       = expand(head[2:0]);
         code_last_d = head[3];
         rep_d       = '0;
      end
      pop = load;

      last_d = valid_d && code_last_d && (rep_d == REP_LAST_C);

      pixel_count_d = pixel_count_q;
      if (out_xfer) begin
         pixel_count_d = last_q ? 32'd0 : pixel_count_q + 32'd1;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = {last_in, compressed_in};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
      // Registered ready: a pop at full only frees a slot from the next cycle on.
      ready_d = (fifo_cnt_d < DEPTH_C);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q       <= IDLE;
         rep_q         <= '0;
         pix_q         <= '0;
         code_last_q   <= 1'b0;
         valid_q       <= 1'b0;
         last_q        <= 1'b0;
         pixel_count_q <= '0;
         ready_q       <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         rep_q         <= rep_d;
         pix_q         <= pix_d;
         code_last_q   <= code_last_d;
         valid_q       <= valid_d;
         last_q        <= last_d;
         pixel_count_q <= pixel_count_d;
         ready_q       <= ready_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         mem_q         <= mem_d;
      end
   end

   assign ready_out       = ready_q;
   assign rgb_out         = pix_q;
   assign last_out        = last_q;
   assign valid_out       = valid_q;
   assign pixel_count_out = pixel_count_q;

endmodule

// File: tb/tb_rgb_expand.sv
// Directed plus randomized bench for rgb_expand: default instance and an
// AVERAGE_OVER=1 instance, each checked against a pixel-queue reference model.
module tb_rgb_expand;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  comp_in;
   logic        last_in, valid_in, ready_in;
   logic        ready_out, last_out, valid_out;
   logic [23:0] rgb_out;
   logic [31:0] pixel_count_out;

   logic [2:0]  comp_in1;
   logic        last_in1, valid_in1, ready_in1;
   logic        ready_out1, last_out1, valid_out1;
   logic [23:0] rgb_out1;
   logic [31:0] pixel_count_out1;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   rgb_expand dut (
      .clk_in(clk), .rst_n_in(rst_n), .compressed_in(comp_in), .last_in(last_in),
      .valid_in(valid_in), .ready_out(ready_out), .rgb_out(rgb_out), .last_out(last_out),
      .valid_out(valid_out), .ready_in(ready_in), .pixel_count_out(pixel_count_out)
   );

   rgb_expand #(.AVERAGE_OVER(1)) dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .compressed_in(comp_in1), .last_in(last_in1),
      .valid_in(valid_in1), .ready_out(ready_out1), .rgb_out(rgb_out1), .last_out(last_out1),
      .valid_out(valid_out1), .ready_in(ready_in1), .pixel_count_out(pixel_count_out1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] ref_pixel(input logic [2:0] c);
      ref_pixel = {c[2] ? 8'd255 : 8'd0, c[1] ? 8'd255 : 8'd0, c[0] ? 8'd255 : 8'd0};
   endfunction

   // Reference model: every accepted code becomes AVERAGE_OVER queued pixels,
   // the last replica carrying the code's frame-end flag.
   logic [24:0] exp_q[$];
   logic [24:0] exp1_q[$];
   logic [31:0] exp_cnt, exp_cnt1;
   logic [24:0] hold_val, e;
   logic        hold_pend;
   int          accepted = 0;
   int          xfers    = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp1_q.delete();
         exp_cnt   = 0;
         exp_cnt1  = 0;
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_valid", valid_out, 1'b1);
            check("hold_payload", {last_out, rgb_out}, hold_val);
         end
         check("pixel_count", pixel_count_out, exp_cnt);
         if (valid_out && ready_in) begin
            xfers++;
            check("xfer_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("pixel", {last_out, rgb_out}, e);
               exp_cnt = e[24] ? 32'd0 : exp_cnt + 32'd1;
            end
         end
         hold_pend = valid_out && !ready_in;
         hold_val  = {last_out, rgb_out};
         if (valid_in && ready_out) begin
            accepted++;
            for (int k = 0; k < 3; k++) begin
               exp_q.push_back({last_in && (k == 2), ref_pixel(comp_in)});
            end
         end

         check("pixel_count_ao1", pixel_count_out1, exp_cnt1);
         if (valid_out1 && ready_in1) begin
            check("xfer_expected_ao1", exp1_q.size() != 0, 1'b1);
            if (exp1_q.size() != 0) begin
               e = exp1_q.pop_front();
               check("pixel_ao1", {last_out1, rgb_out1}, e);
               exp_cnt1 = e[24] ? 32'd0 : exp_cnt1 + 32'd1;
            end
         end
         if (valid_in1 && ready_out1) begin
            exp1_q.push_back({last_in1, ref_pixel(comp_in1)});
         end
      end
   end

   initial begin
      int base;
      int k;
      int n_acc;
      logic acc;
      logic [2:0] c;

      rst_n = 1'b1;
      comp_in = '0; last_in = 0; valid_in = 0; ready_in = 0;
      comp_in1 = '0; last_in1 = 0; valid_in1 = 0; ready_in1 = 1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_valid", valid_out, 0);
      check("rst_rgb", rgb_out, 0);
      check("rst_last", last_out, 0);
      check("rst_count", pixel_count_out, 0);
      check("rst_ready", ready_out, 0);
      tick; tick;
      rst_n = 1'b1;
      check("ready_before_edge", ready_out, 0);
      tick;
      check("ready_after_edge", ready_out, 1);
      check("ready_after_edge_ao1", ready_out1, 1);

      // Single code, three replicas.
      ready_in = 1; valid_in = 1; comp_in = 3'b101; last_in = 0;
      tick;
      valid_in = 0;
      check("t1_latency_valid", valid_out, 0);
      tick;
      for (int i = 0; i < 3; i++) begin
         check("t1_valid", valid_out, 1);
         check("t1_rgb", rgb_out, 24'hFF00FF);
         check("t1_count", pixel_count_out, i);
         tick;
      end
      check("t1_idle", valid_out, 0);
      check("t1_count_end", pixel_count_out, 3);

      // Back-to-back codes with no bubble; frame ends on the sixth pixel.
      valid_in = 1; comp_in = 3'b111; last_in = 0;
      tick;
      comp_in = 3'b000; last_in = 1;
      tick;
      valid_in = 0; last_in = 0;
      for (int i = 0; i < 6; i++) begin
         check("t2_valid", valid_out, 1);
         check("t2_rgb", rgb_out, (i < 3) ? 24'hFFFFFF : 24'h000000);
         check("t2_last", last_out, i == 5);
         tick;
      end
      check("t2_idle", valid_out, 0);
      check("t2_count_zero", pixel_count_out, 0);

      // Backpressure during the second replica.
      base = xfers;
      valid_in = 1; comp_in = 3'b010;
      tick;
      valid_in = 0;
      tick; tick;
      ready_in = 0;
      for (int i = 0; i < 5; i++) begin
         check("t3_stall_valid", valid_out, 1);
         check("t3_stall_rgb", rgb_out, 24'h00FF00);
         tick;
      end
      ready_in = 1;
      tick; tick;
      check("t3_idle", valid_out, 0);
      check("t3_xfers", xfers - base, 3);

      // Fill: output register plus FIFO hold five codes.
      base = accepted; n_acc = 0; k = 1;
      ready_in = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         valid_in = 1; comp_in = k[2:0];
         acc = ready_out;
         tick;
         if (acc) begin
            n_acc++;
            k++;
            if (n_acc == 5) check("t4_ready_low", ready_out, 0);
         end
      end
      valid_in = 0;
      check("t4_accepted", accepted - base, 5);
      check("t4_ready_full", ready_out, 0);
      ready_in = 1;
      tick;
      check("t4_ready_still_low0", ready_out, 0);
      tick;
      check("t4_ready_still_low1", ready_out, 0);
      tick;
      check("t4_ready_back", ready_out, 1);
      for (int i = 0; i < 12; i++) tick;
      check("t4_idle", valid_out, 0);
      check("t4_drained", exp_q.size(), 0);

      // Asynchronous reset mid-frame.
      valid_in = 1; comp_in = 3'b110;
      tick;
      valid_in = 0;
      tick; tick;
      #2 rst_n = 1'b0;
      #1;
      check("t5_valid", valid_out, 0);
      check("t5_last", last_out, 0);
      check("t5_rgb", rgb_out, 0);
      check("t5_count", pixel_count_out, 0);
      check("t5_ready", ready_out, 0);
      tick; tick;
      rst_n = 1'b1;
      tick;
      check("t5_ready_back", ready_out, 1);
      valid_in = 1; comp_in = 3'b100;
      tick;
      valid_in = 0;
      tick;
      for (int i = 0; i < 3; i++) begin
         check("t5_rgb_after", rgb_out, 24'hFF0000);
         check("t5_count_after", pixel_count_out, i);
         tick;
      end
      check("t5_count_end", pixel_count_out, 3);

      // AVERAGE_OVER=1 instance streaming one code per cycle.
      for (int i = 0; i < 20; i++) begin
         c = 3'($urandom_range(0, 7));
         valid_in1 = 1; comp_in1 = c; last_in1 = ($urandom_range(0, 3) == 0);
         check("t6_ready", ready_out1, 1);
         if (i >= 2) check("t6_stream_valid", valid_out1, 1);
         tick;
      end
      valid_in1 = 0; last_in1 = 0;
      for (int i = 0; i < 4; i++) tick;
      check("t6_idle", valid_out1, 0);
      check("t6_drained", exp1_q.size(), 0);

      // Random traffic on the default instance.
      for (int i = 0; i < 200; i++) begin
         valid_in = ($urandom_range(0, 1) == 1);
         comp_in  = 3'($urandom_range(0, 7));
         last_in  = ($urandom_range(0, 3) == 0);
         ready_in = ($urandom_range(0, 3) != 0);
         tick;
      end
      valid_in = 0; last_in = 0; ready_in = 1;
      for (int i = 0; i < 40; i++) tick;
      check("rand_idle", valid_out, 0);
      check("rand_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
